// File: rtl/rob_commit_ctrl_if.sv
// Dispatch, exception, status-lookup, commit and flush signals between the
// ROB retirement controller and the rest of the core.
interface rob_commit_ctrl_if;
  logic       disp_valid_i;
  logic       disp_slot1_valid_i;
  logic       disp_ready_o;
  logic [3:0] disp_row_o;
  logic       excp_valid_i;
  logic [4:0] excp_slot_i;
  logic [4:0] rob0_status_o;
  logic       rob0_status_i;
  logic       commit0_o;
  logic [4:0] rob1_status_o;
  logic       rob1_status_i;
  logic       commit1_o;
  logic       flush_o;
  logic [4:0] flush_slot_o;

  // Core / completion-file side.
  modport master (
    output disp_valid_i, disp_slot1_valid_i, excp_valid_i, excp_slot_i,
           rob0_status_i, rob1_status_i,
    input  disp_ready_o, disp_row_o, rob0_status_o, rob1_status_o,
           commit0_o, commit1_o, flush_o, flush_slot_o
  );

  // Retirement controller side.
  modport slave (
    input  disp_valid_i, disp_slot1_valid_i, excp_valid_i, excp_slot_i,
           rob0_status_i, rob1_status_i,
    output disp_ready_o, disp_row_o, rob0_status_o, rob1_status_o,
           commit0_o, commit1_o, flush_o, flush_slot_o
  );
endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order retirement controller for a 16-row x 2-slot reorder buffer:
// row allocation, dual-bank commit and exception-driven pipeline flush.
module rob_commit_ctrl #(
  parameter int ROB_ROWS = 16
) (
  input logic              cpu_clk_i,
  input logic              cpu_rst_i,
  rob_commit_ctrl_if.slave bus
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                  state;
  logic [3:0]              head;
  logic [3:0]              tail;
  logic [4:0]              count;
  logic [ROB_ROWS-1:0]     valid0;
  logic [ROB_ROWS-1:0]     valid1;
  logic [2*ROB_ROWS-1:0]   excp;
  logic                    half_done;
  logic                    flush_q;
  logic [4:0]              flush_slot_q;

  logic       active;
  logic [4:0] slot0;
  logic [4:0] slot1;
  logic       head_v0;
  logic       head_v1;
  logic       head_e0;
  logic       head_e1;
  logic       c0;
  logic       c1;
  logic       s0_done;
  logic       trig0;
  logic       trig1;
  logic       retire;
  logic       disp_ready;
  logic       disp_fire;
  logic       excp_ok;

  assign active  = (state == RUN) && (count != 5'd0);
  assign slot0   = {head, 1'b0};
  assign slot1   = {head, 1'b1};
  assign head_v0 = valid0[head];
  assign head_v1 = valid1[head];
  assign head_e0 = excp[slot0];
  assign head_e1 = excp[slot1];

  // The odd slot may only go once the even slot is retired, either earlier
  // (half_done) or in this same cycle.
  assign c0      = active && head_v0 && !half_done && bus.rob0_status_i && !head_e0;
  assign s0_done = half_done || c0;
  assign c1      = active && head_v1 && s0_done && bus.rob1_status_i && !head_e1;
  assign trig0   = active && head_v0 && !half_done && bus.rob0_status_i && head_e0;
  assign trig1   = active && head_v1 && s0_done && bus.rob1_status_i && head_e1;
  assign retire  = active && s0_done && (!head_v1 || c1);

  assign disp_ready = (count != 5'(ROB_ROWS)) && (state == RUN);
  assign disp_fire  = bus.disp_valid_i && disp_ready;
  assign excp_ok    = bus.excp_valid_i &&
                      (bus.excp_slot_i[0] ? valid1[bus.excp_slot_i[4:1]]
                                          : valid0[bus.excp_slot_i[4:1]]);

  assign bus.disp_ready_o  = disp_ready;
  assign bus.disp_row_o    = tail;
  assign bus.rob0_status_o = slot0;
  assign bus.rob1_status_o = slot1;
  assign bus.commit0_o     = c0;
  assign bus.commit1_o     = c1;
  assign bus.flush_o       = flush_q;
  assign bus.flush_slot_o  = flush_slot_q;

  // The single FLUSH cycle ends by wiping the ROB exactly like a reset.
  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i || state == FLUSH) begin
      state        <= RUN;
      head         <= 4'd0;
      tail         <= 4'd0;
      count        <= 5'd0;
      valid0       <= '0;
      valid1       <= '0;
      excp         <= '0;
      half_done    <= 1'b0;
      flush_q      <= 1'b0;
      flush_slot_q <= 5'd0;
    end else begin
      if (excp_ok)
        excp[bus.excp_slot_i] <= 1'b1;

      if (disp_fire) begin
        valid0[tail]        <= 1'b1;
        valid1[tail]        <= bus.disp_slot1_valid_i;
        excp[{tail, 1'b0}]  <= 1'b0;
        excp[{tail, 1'b1}]  <= 1'b0;
        tail                <= tail + 4'd1;
      end

      if (retire) begin
        valid0[head] <= 1'b0;
        valid1[head] <= 1'b0;
        head         <= head + 4'd1;
        half_done    <= 1'b0;
      end else if (c0) begin
        half_done <= 1'b1;
      end

      case ({disp_fire, retire})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase

      if (trig0 || trig1) begin
        state        <= FLUSH;
        flush_q      <= 1'b1;
        flush_slot_q <= trig0 ? slot0 : slot1;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl; a small completion-file model answers
// the status lookups and is cleared by commits and flushes.
module tb_rob_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] done;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  rob_commit_ctrl_if bus();

  assign bus.rob0_status_i = done[bus.rob0_status_o];
  assign bus.rob1_status_i = done[bus.rob1_status_o];

  rob_commit_ctrl #(.ROB_ROWS(16)) dut (
    .cpu_clk_i (clk),
    .cpu_rst_i (rst),
    .bus       (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic dv, input logic s1v, input logic ev, input logic [4:0] es);
    bus.disp_valid_i       = dv;
    bus.disp_slot1_valid_i = s1v;
    bus.excp_valid_i       = ev;
    bus.excp_slot_i        = es;
  endtask

  // Advance one clock; commits and flushes seen before the edge clear the model.
  task automatic tick();
    logic       k0, k1, fl;
    logic [4:0] i0, i1;
    k0 = bus.commit0_o;
    k1 = bus.commit1_o;
    fl = bus.flush_o;
    i0 = bus.rob0_status_o;
    i1 = bus.rob1_status_o;
    @(posedge clk);
    #1;
    if (k0) done[i0] = 1'b0;
    if (k1) done[i1] = 1'b0;
    if (fl) done = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    done = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got 0 expected 1");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    doReset();
    #1;
    checkOutput("rst_flush", bus.flush_o, 32'd0);
    checkOutput("rst_c0", bus.commit0_o, 32'd0);
    checkOutput("rst_c1", bus.commit1_o, 32'd0);
    checkOutput("rst_ready", bus.disp_ready_o, 32'd1);
    checkOutput("rst_row", bus.disp_row_o, 32'd0);
    checkOutput("rst_count", dut.count, 32'd0);
    done = '1;
    #1;
    checkOutput("empty_c0", bus.commit0_o, 32'd0);
    checkOutput("empty_c1", bus.commit1_o, 32'd0);
    done = '0;

    // Three full rows, all complete: dual retire on three consecutive cycles.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    checkOutput("burst_row", bus.disp_row_o, 32'd3);
    checkOutput("burst_count", dut.count, 32'd3);
    done[5:0] = 6'h3f;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("burst_c0", bus.commit0_o, 32'd1);
      checkOutput("burst_c1", bus.commit1_o, 32'd1);
      checkOutput("burst_head", bus.rob0_status_o, 32'(2 * i));
      checkOutput("burst_cnt", dut.count, 32'(3 - i));
      tick();
      #1;
    end
    checkOutput("burst_head_end", bus.rob0_status_o, 32'd6);
    checkOutput("burst_count_end", dut.count, 32'd0);
    checkOutput("burst_c0_end", bus.commit0_o, 32'd0);

    // Split retire of row 3: even now, odd two cycles later.
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    done[6] = 1'b1;
    #1;
    checkOutput("half_c0", bus.commit0_o, 32'd1);
    checkOutput("half_c1", bus.commit1_o, 32'd0);
    tick();
    #1;
    checkOutput("half_flag", dut.half_done, 32'd1);
    checkOutput("half_head", bus.rob0_status_o, 32'd6);
    checkOutput("half_c0_held", bus.commit0_o, 32'd0);
    checkOutput("half_c1_held", bus.commit1_o, 32'd0);
    tick();
    done[7] = 1'b1;
    #1;
    checkOutput("late_c1", bus.commit1_o, 32'd1);
    checkOutput("late_c0", bus.commit0_o, 32'd0);
    tick();
    #1;
    checkOutput("late_head", bus.rob0_status_o, 32'd8);
    checkOutput("late_count", dut.count, 32'd0);

    // Single-instruction row 4: odd status high must not commit.
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    done[8] = 1'b1;
    done[9] = 1'b1;
    #1;
    checkOutput("single_c0", bus.commit0_o, 32'd1);
    checkOutput("single_c1", bus.commit1_o, 32'd0);
    tick();
    #1;
    checkOutput("single_head", bus.rob0_status_o, 32'd10);
    checkOutput("single_count", dut.count, 32'd0);
    done[9] = 1'b0;

    // Fill all 16 rows starting at row 5; tail wraps 15 -> 0.
    for (int i = 0; i < 16; i++) begin
      checkOutput("fill_row", bus.disp_row_o, 32'((5 + i) % 16));
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      tick();
    end
    checkOutput("full_count", dut.count, 32'd16);
    checkOutput("full_ready", bus.disp_ready_o, 32'd0);
    checkOutput("full_row", bus.disp_row_o, 32'd5);
    tick();
    #1;
    checkOutput("full_ignored_cnt", dut.count, 32'd16);
    checkOutput("full_ignored_row", bus.disp_row_o, 32'd5);
    done[10] = 1'b1;
    done[11] = 1'b1;
    #1;
    checkOutput("full_ret_c0", bus.commit0_o, 32'd1);
    checkOutput("full_ret_c1", bus.commit1_o, 32'd1);
    checkOutput("full_ret_ready", bus.disp_ready_o, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    #1;
    checkOutput("after_ret_ready", bus.disp_ready_o, 32'd1);
    checkOutput("after_ret_count", dut.count, 32'd15);
    checkOutput("after_ret_head", bus.rob0_status_o, 32'd12);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    checkOutput("refill_count", dut.count, 32'd16);
    checkOutput("refill_row", bus.disp_row_o, 32'd6);

    doReset();
    #1;
    checkOutput("rst2_count", dut.count, 32'd0);
    checkOutput("rst2_row", bus.disp_row_o, 32'd0);

    // Exception on slot 5: rows 0-1 retire, slot 4 commits, then flush.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd5);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    checkOutput("excp_capture", dut.excp[5], 32'd1);
    done[5:0] = 6'h3f;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("ex_row_c0", bus.commit0_o, 32'd1);
      checkOutput("ex_row_c1", bus.commit1_o, 32'd1);
      checkOutput("ex_row_flush", bus.flush_o, 32'd0);
      tick();
      #1;
    end
    checkOutput("ex_slot4_c0", bus.commit0_o, 32'd1);
    checkOutput("ex_slot5_c1", bus.commit1_o, 32'd0);
    checkOutput("ex_pre_flush", bus.flush_o, 32'd0);
    tick();
    #1;
    checkOutput("flush_on", bus.flush_o, 32'd1);
    checkOutput("flush_slot", bus.flush_slot_o, 32'd5);
    checkOutput("flush_c0", bus.commit0_o, 32'd0);
    checkOutput("flush_c1", bus.commit1_o, 32'd0);
    checkOutput("flush_ready", bus.disp_ready_o, 32'd0);
    tick();
    #1;
    checkOutput("post_flush", bus.flush_o, 32'd0);
    checkOutput("post_count", dut.count, 32'd0);
    checkOutput("post_head", bus.rob0_status_o, 32'd0);
    checkOutput("post_tail", bus.disp_row_o, 32'd0);
    checkOutput("post_ready", bus.disp_ready_o, 32'd1);

    // Exception on an invalid slot is dropped; incomplete excepting slot stalls.
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd0);
    #1;
    checkOutput("excp_discard", dut.excp[1], 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    checkOutput("stall_c0", bus.commit0_o, 32'd0);
    tick();
    #1;
    checkOutput("stall_flush", bus.flush_o, 32'd0);
    checkOutput("stall_count", dut.count, 32'd1);
    done[0] = 1'b1;
    #1;
    checkOutput("trig_even_c0", bus.commit0_o, 32'd0);
    tick();
    #1;
    checkOutput("flush2_on", bus.flush_o, 32'd1);
    checkOutput("flush2_slot", bus.flush_slot_o, 32'd0);

    // Reset asserted during FLUSH.
    rst = 1'b1;
    tick();
    #1;
    checkOutput("rst_flush_off", bus.flush_o, 32'd0);
    checkOutput("rst_flush_cnt", dut.count, 32'd0);
    checkOutput("rst_flush_half", dut.half_done, 32'd0);
    checkOutput("rst_flush_row", bus.disp_row_o, 32'd0);
    rst = 1'b0;
    tick();
    #1;
    checkOutput("rst_flush_run", bus.disp_ready_o, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- In-order retirement controller for the 32-entry reorder buffer (ROB). The ROB is organised as 16 rows of 2 slots: even slots form bank 0 and odd slots form bank 1.
- Allocates rows at dispatch and drives the per-bank status lookup indices into the completion-status file.
- Consumes the returned completion bits and issues the commit0/commit1 strobes that clear them. Up to 2 instructions retire per cycle.
- Detects excepting instructions at the head and generates the single-cycle pipeline flush, which also clears the completion-status file.

Parameters:
- ROB_ROWS, 16, number of 2-slot rows. Fixed at 16 to match the 5-bit ROB slot ids; slot id = {row[3:0], bank}.

Ports:
- cpu_clk_i  in  1  core clock
- cpu_rst_i  in  1  synchronous active-high reset
- disp_valid_i  in  1  dispatch a row this cycle
- disp_slot1_valid_i  in  1  odd slot of the dispatched row holds an instruction (the even slot is always valid when disp_valid_i)
- disp_ready_o  out  1  a row can be accepted
- disp_row_o  out  4  row allocated on this cycle's dispatch; slot ids are {disp_row_o,0} and {disp_row_o,1}
- excp_valid_i  in  1  an execution unit reports an exception
- excp_slot_i  in  5  ROB slot of the excepting instruction
- rob0_status_o  out  5  even-bank lookup index = {head,0}
- rob0_status_i  in  1  completion bit of rob0_status_o (combinational return)
- commit0_o  out  1  retire even slot of the head row
- rob1_status_o  out  5  odd-bank lookup index = {head,1}
- rob1_status_i  in  1  completion bit of rob1_status_o
- commit1_o  out  1  retire odd slot of the head row
- flush_o  out  1  one-cycle pipeline flush; also drives the completion file's flush
- flush_slot_o  out  5  slot id of the excepting instruction, valid while flush_o

Behaviour:
- State: head[3:0], tail[3:0], count[4:0] (0..16), and per-row valid0/valid1. Also per-slot excp bit (32), a half_done flag for the head row, an FSM {RUN, FLUSH}, and a registered flush slot.
- Reset (cpu_rst_i=1), which wins over everything:
  - head=tail=count=0; all valid, excp and half_done cleared; FSM=RUN.
  - flush_o=0, commit0_o=commit1_o=0.
- Dispatch:
  - disp_ready_o = (count != 16) && FSM==RUN, computed from registered state only.
  - On disp_valid_i && disp_ready_o: row[tail] gets valid0=1, valid1=disp_slot1_valid_i, both excp bits cleared; tail+1 (mod 16, wraps 15->0).
  - disp_row_o = tail.
  - disp_valid_i without ready is ignored.
- Exception capture: on excp_valid_i, set excp[excp_slot_i] next edge. Exceptions reported for slots not valid are discarded.
- Commit (combinational, FSM==RUN, count!=0). Let h = head row.
  - c0 = valid0[h] && !half_done && rob0_status_i && !excp[{h,0}].
  - s0_done = half_done || c0.
  - c1 = valid1[h] && s0_done && rob1_status_i && !excp[{h,1}].
  - commit0_o = c0; commit1_o = c1. Odd never retires before even.
- Row retire: when s0_done && (!valid1[h] || c1), the row retires: valid cleared, head+1 mod 16, half_done=0.
- Partial retire: c0 without retire sets half_done=1 and head is held.
- Counter: dispatch and retire in the same cycle leave count unchanged. A retire while full does not raise disp_ready_o until the next cycle.
- Exception at head:
  - Trigger: in RUN, the next in-order unretired slot is valid, its status is 1, and its excp bit is set. The next in-order slot is the even slot if !half_done, else the odd slot; it is also the odd slot when c0 fires the same cycle and the odd slot excepts.
  - On trigger, that slot is not committed and FSM goes to FLUSH; the older even slot still commits if c0.
  - FLUSH lasts exactly one cycle: flush_o=1, flush_slot_o = captured slot, no commits, no dispatch.
  - At the end of FLUSH, all ROB state is cleared as at reset and FSM returns to RUN.
- An incomplete excepting slot does not trigger the flush; the head simply stalls.
- Empty ROB (count==0): commit0_o=commit1_o=0, regardless of the status inputs.

Test Plan:
- Reset, dispatch 3 full rows, complete all 6 slots -> commit0_o=commit1_o=1 on 3 consecutive cycles; head 0->3; count 3->0.
- Row 0 slot 0 complete, slot 1 completes 2 cycles later -> commit0_o alone at cycle t, half_done=1, commit1_o alone at t+2, then head=1.
- Dispatch a single-instruction row (disp_slot1_valid_i=0), complete slot 0 -> commit0_o=1, commit1_o=0, row retires in 1 cycle.
- Fill 16 rows -> disp_ready_o=0 at count=16. Retire 1 row -> disp_ready_o=1 next cycle. Dispatch wraps tail 15->0.
- excp_valid_i on slot 5 (row 2 odd), rows 0-2 complete -> rows 0-1 retire, slot 4 commits, slot 5 does not. flush_o=1 for one cycle with flush_slot_o=5, then count=0 and head=tail=0.
- cpu_rst_i asserted during FLUSH -> flush_o=0 next cycle and all state cleared.
